// File: rtl/rhythm_pkg.sv
// rhythm_pkg: shared game-phase encoding, keycodes and score limits for the rhythm game
package rhythm_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DONE = 2'b10} game_state_t;
  localparam logic [7:0] KEY_START = 8'h2C;
  localparam logic [7:0] KEY_RESTART = 8'h01;
  localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;
endpackage

// File: rtl/score_tally_if.sv
// score_tally_if: keycodes and dropper hit flags in, score/HUD status out
interface score_tally_if #(parameter int NUM_LANES = 16);
  logic [7:0] keycode;
  logic [7:0] keycode_second;
  logic [NUM_LANES-1:0] score_vec;
  logic [15:0] score_bcd;
  logic [11:0] hits_total;
  logic [5:0] new_hits;
  logic flash_on;
  logic [1:0] game_state;
  modport master(output keycode, keycode_second, score_vec, input score_bcd, hits_total, new_hits, flash_on, game_state);
  modport slave(input keycode, keycode_second, score_vec, output score_bcd, hits_total, new_hits, flash_on, game_state);
endinterface

// File: rtl/score_tally_bcd_add_sat.sv
// bcd_add_sat: adds a binary delta to a 4-digit BCD value, saturating at 9999
module bcd_add_sat
  import rhythm_pkg::*;
(
  input  logic [15:0] acc,
  input  logic [9:0]  delta,
  output logic [15:0] sum
);
  logic [15:0] d_bcd;
  logic [15:0] raw;
  logic [4:0] t;
  logic c;
  assign d_bcd = {4'(delta / 1000), 4'((delta / 100) % 10), 4'((delta / 10) % 10), 4'(delta % 10)};
  always_comb begin
    c = 1'b0;
    t = '0;
    raw = '0;
    for (int i = 0; i < 4; i++) begin
      t = 5'(acc[4*i +: 4]) + 5'(d_bcd[4*i +: 4]) + 5'(c);
      c = t > 5'd9;
      raw[4*i +: 4] = c ? 4'(t + 5'd6) : t[3:0];
    end
    sum = c ? SCORE_MAX_BCD : raw;
  end
endmodule

// File: rtl/score_tally.sv
// score_tally: turns dropper hit-flag rising edges into BCD score, hit total and HUD flash
module score_tally
  import rhythm_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int POINTS_PER_HIT = 1,
  parameter int SONG_FRAMES = 4000,
  parameter int FLASH_FRAMES = 8
) (
  input logic frame_clk,
  input logic Reset,
  score_tally_if.slave bus
);
  game_state_t state;
  logic [NUM_LANES-1:0] prev_vec;
  logic [NUM_LANES-1:0] rise;
  logic [5:0] pop;
  logic [9:0] delta;
  logic [12:0] hsum;
  logic [15:0] score_next;
  logic [15:0] frame_cnt;
  logic [7:0] flash_cnt;
  logic start, restart;
  assign rise = bus.score_vec & ~prev_vec;
  assign delta = 10'(pop * POINTS_PER_HIT);
  assign hsum = {1'b0, bus.hits_total} + 13'(pop);
  assign start = bus.keycode == KEY_START || bus.keycode_second == KEY_START;
  assign restart = bus.keycode == KEY_RESTART || bus.keycode_second == KEY_RESTART;
  assign bus.flash_on = flash_cnt != 0;
  assign bus.game_state = state;
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_LANES; i++) pop = pop + 6'(rise[i]);
  end
  bcd_add_sat u_add (.acc(bus.score_bcd), .delta(delta), .sum(score_next));
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state <= IDLE;
      prev_vec <= '0;
      bus.score_bcd <= '0;
      bus.hits_total <= '0;
      bus.new_hits <= '0;
      frame_cnt <= '0;
      flash_cnt <= '0;
    end else begin
      prev_vec <= bus.score_vec;
      bus.new_hits <= '0;
      flash_cnt <= '0;
      case (state)
        IDLE: if (start) begin
          state <= PLAY;
          bus.score_bcd <= '0;
          bus.hits_total <= '0;
          frame_cnt <= '0;
        end
        PLAY: begin
          bus.new_hits <= pop;
          bus.hits_total <= hsum[12] ? 12'hFFF : hsum[11:0];
          bus.score_bcd <= score_next;
          flash_cnt <= pop != 0 ? 8'(FLASH_FRAMES) : (flash_cnt != 0 ? flash_cnt - 8'd1 : 8'd0);
          frame_cnt <= frame_cnt + 16'd1;
          if (frame_cnt == 16'(SONG_FRAMES - 1)) state <= DONE;
        end
        DONE: if (restart) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_score_tally.sv
// tb_score_tally: directed checks of scoring, saturation, song end and reset on three configurations
module tb_score_tally;
  logic frame_clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  int checks = 0, errors = 0;
  always #5 frame_clk = ~frame_clk;
  score_tally_if #(.NUM_LANES(16)) a_if();
  score_tally_if #(.NUM_LANES(16)) b_if();
  score_tally_if #(.NUM_LANES(16)) c_if();
  score_tally #(.NUM_LANES(16), .POINTS_PER_HIT(3), .SONG_FRAMES(4000), .FLASH_FRAMES(8))
    dut_a (.frame_clk(frame_clk), .Reset(rst_a), .bus(a_if));
  score_tally #(.NUM_LANES(16), .POINTS_PER_HIT(1), .SONG_FRAMES(10), .FLASH_FRAMES(8))
    dut_b (.frame_clk(frame_clk), .Reset(rst_b), .bus(b_if));
  score_tally #(.NUM_LANES(16), .POINTS_PER_HIT(1), .SONG_FRAMES(4000), .FLASH_FRAMES(8))
    dut_c (.frame_clk(frame_clk), .Reset(rst_c), .bus(c_if));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask
  initial begin
    {a_if.keycode, a_if.keycode_second, a_if.score_vec} = '0;
    {b_if.keycode, b_if.keycode_second, b_if.score_vec} = '0;
    {c_if.keycode, c_if.keycode_second, c_if.score_vec} = '0;
    tick();
    tick();
    {rst_a, rst_b, rst_c} = 3'b000;
    check("rst_state", a_if.game_state, 0);
    check("rst_score", a_if.score_bcd, 0);
    check("rst_hits", a_if.hits_total, 0);
    check("rst_new", a_if.new_hits, 0);
    check("rst_flash", a_if.flash_on, 0);
    // single-lane hit, flash length, decimal carry and saturation on dut_c
    c_if.keycode = 8'h2C;
    tick();
    c_if.keycode = 8'h00;
    check("c_start_state", c_if.game_state, 1);
    check("c_start_score", c_if.score_bcd, 0);
    check("c_start_hits", c_if.hits_total, 0);
    c_if.score_vec = 16'h0008;
    tick();
    check("c_bit3_new", c_if.new_hits, 1);
    check("c_bit3_score", c_if.score_bcd, 16'h0001);
    check("c_bit3_hits", c_if.hits_total, 1);
    check("c_flash_0", c_if.flash_on, 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("c_flash_%0d", i), c_if.flash_on, 1);
      check($sformatf("c_held_new_%0d", i), c_if.new_hits, 0);
    end
    tick();
    check("c_flash_off", c_if.flash_on, 0);
    check("c_held_score", c_if.score_bcd, 16'h0001);
    c_if.score_vec = '0;
    tick();
    for (int i = 0; i < 6; i++) begin
      c_if.score_vec = 16'hFFFF;
      tick();
      c_if.score_vec = '0;
      tick();
    end
    c_if.score_vec = 16'h0001;
    tick();
    c_if.score_vec = '0;
    tick();
    check("c_score_98", c_if.score_bcd, 16'h0098);
    c_if.score_vec = 16'h0003;
    tick();
    check("c_carry_100", c_if.score_bcd, 16'h0100);
    check("c_carry_new", c_if.new_hits, 2);
    check("c_hits_100", c_if.hits_total, 100);
    c_if.score_vec = '0;
    tick();
    for (int i = 0; i < 618; i++) begin
      c_if.score_vec = 16'hFFFF;
      tick();
      c_if.score_vec = '0;
      tick();
    end
    c_if.score_vec = 16'h007F;
    tick();
    c_if.score_vec = '0;
    tick();
    check("c_score_9995", c_if.score_bcd, 16'h9995);
    check("c_hits_sat", c_if.hits_total, 4095);
    c_if.score_vec = 16'h0007;
    tick();
    check("c_score_9998", c_if.score_bcd, 16'h9998);
    c_if.score_vec = '0;
    tick();
    c_if.score_vec = 16'h0001;
    tick();
    check("c_score_9999", c_if.score_bcd, 16'h9999);
    c_if.score_vec = '0;
    tick();
    c_if.score_vec = 16'h0001;
    tick();
    check("c_sat_1", c_if.score_bcd, 16'h9999);
    c_if.score_vec = '0;
    tick();
    c_if.score_vec = 16'hFFFF;
    tick();
    check("c_sat_16", c_if.score_bcd, 16'h9999);
    check("c_sat_new", c_if.new_hits, 16);
    check("c_sat_state", c_if.game_state, 1);
    // multi-lane hits with 3 points each, then reset mid-game on dut_a
    a_if.keycode_second = 8'h2C;
    tick();
    a_if.keycode_second = 8'h00;
    check("a_start_state", a_if.game_state, 1);
    a_if.score_vec = 16'h0221;
    tick();
    check("a_multi_new", a_if.new_hits, 3);
    check("a_multi_score", a_if.score_bcd, 16'h0009);
    a_if.score_vec = '0;
    tick();
    a_if.score_vec = 16'h07FF;
    tick();
    check("a_score_42", a_if.score_bcd, 16'h0042);
    check("a_hits_14", a_if.hits_total, 14);
    check("a_flash_on", a_if.flash_on, 1);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("a_rst_state", a_if.game_state, 0);
    check("a_rst_score", a_if.score_bcd, 0);
    check("a_rst_flash", a_if.flash_on, 0);
    check("a_rst_new", a_if.new_hits, 0);
    check("a_rst_hits", a_if.hits_total, 0);
    // pre-held flag, song end, DONE behaviour and restart on dut_b
    b_if.score_vec = 16'h0004;
    b_if.keycode = 8'h2C;
    tick();
    check("b_start_state", b_if.game_state, 1);
    tick();
    b_if.keycode = 8'h00;
    check("b_prehigh_new", b_if.new_hits, 0);
    check("b_prehigh_hits", b_if.hits_total, 0);
    check("b_start_ignored", b_if.game_state, 1);
    for (int i = 0; i < 8; i++) tick();
    check("b_frame9_state", b_if.game_state, 1);
    b_if.score_vec = 16'h0084;
    tick();
    check("b_done_state", b_if.game_state, 2);
    check("b_last_new", b_if.new_hits, 1);
    check("b_last_score", b_if.score_bcd, 16'h0001);
    b_if.score_vec = '0;
    tick();
    b_if.score_vec = 16'h00F0;
    tick();
    check("b_done_new", b_if.new_hits, 0);
    check("b_done_score", b_if.score_bcd, 16'h0001);
    check("b_done_flash", b_if.flash_on, 0);
    b_if.keycode = 8'h2C;
    tick();
    check("b_done_start_ign", b_if.game_state, 2);
    b_if.keycode = 8'h00;
    b_if.keycode_second = 8'h01;
    tick();
    b_if.keycode_second = 8'h00;
    check("b_idle_state", b_if.game_state, 0);
    check("b_idle_score", b_if.score_bcd, 16'h0001);
    check("b_idle_hits", b_if.hits_total, 1);
    b_if.score_vec = '0;
    tick();
    b_if.score_vec = 16'h0001;
    tick();
    check("b_idle_ignore", b_if.score_bcd, 16'h0001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/score_tally.md
Name: score_tally

Overview:
- Consumes the one-bit hit flags (`scoreNN`) from all falling-arrow droppers and turns them into the game's running score.
- Detects the rising edge of each hit flag, so every note counts exactly once.
- Accumulates a 4-digit BCD score and a binary hit total, and raises a short "hit flash" pulse for the HUD.
- Sits between the dropper array and the text/score renderer. Tracks game phase from the same start/reset keycodes the droppers use.

Parameters:
- NUM_LANES, 16, number of dropper hit flags on score_vec (1..63).
- POINTS_PER_HIT, 1, BCD points added per hit (1..9).
- SONG_FRAMES, 4000, frames after start until the game ends.
- FLASH_FRAMES, 8, frames flash_on stays high after the last hit.

Ports:
- frame_clk  in  1  frame-rate clock (one edge per video frame).
- Reset  in  1  synchronous, active-high reset.
- keycode  in  8  primary USB keycode.
- keycode_second  in  8  secondary USB keycode.
- score_vec  in  NUM_LANES  hit flags from droppers, bit i = dropper i.
- score_bcd  out  16  four BCD digits, [15:12] is thousands.
- hits_total  out  12  binary count of hits, saturating at 4095.
- new_hits  out  6  number of hits registered on the last frame.
- flash_on  out  1  hit-flash request to the renderer.
- game_state  out  2  00 IDLE, 01 PLAY, 10 DONE.

Behaviour:
- All state is registered on posedge frame_clk. Reset has priority over everything else.
- Reset values: state IDLE, score_bcd 0, hits_total 0, new_hits 0, flash_on 0, frame counter 0, prev_vec 0.
- FSM transitions (start/end keys match on either keycode port):
  - IDLE -> PLAY when keycode or keycode_second == 8'h2C. Entering PLAY clears score_bcd, hits_total and the frame counter.
  - PLAY -> DONE when frame counter == SONG_FRAMES-1. The counter increments every PLAY frame.
  - DONE -> IDLE when either keycode == 8'h01.
  - No other transitions. 8'h2C in PLAY or DONE is ignored.
- Edge detect:
  - rise = score_vec & ~prev_vec.
  - prev_vec <= score_vec every frame in every state, so a flag already high on entering PLAY never counts.
- Hit accounting, PLAY only:
  - new_hits <= popcount(rise).
  - hits_total <= hits_total + popcount(rise), clamped at 4095.
  - The score delta is popcount(rise) * POINTS_PER_HIT, computed in binary, at most 9*63 = 567.
  - The delta is added to score_bcd by a BCD adder with decimal carry across all 4 digits.
  - If the true sum exceeds 9999, score_bcd = 16'h9999 (saturate; never wraps).
  - Latency: a hit flag rising at edge k shows in score_bcd, hits_total and new_hits after edge k+1.
- Outside PLAY: new_hits <= 0 and rises are ignored. Score and hits_total hold their values in DONE and IDLE until the next start.
- flash_on: a down-counter is loaded with FLASH_FRAMES on any PLAY frame where popcount(rise) != 0; otherwise it decrements to 0. flash_on = (counter != 0). The counter is forced to 0 outside PLAY.
- Simultaneous events:
  - Several lanes rising on one frame are all counted.
  - A rise on the same frame as the PLAY->DONE transition is still counted.
- Reset mid-game clears everything and returns to IDLE on that edge.

Decomposition:
- Shared package `rhythm_pkg`, holding:
  - enum game_state_t {IDLE, PLAY, DONE} encoded 2 bits;
  - constants KEY_START = 8'h2C and KEY_RESTART = 8'h01;
  - constant SCORE_MAX_BCD = 16'h9999.
- One sub-module, `bcd_add_sat`:
  - combinational, 16-bit BCD accumulator plus a 10-bit binary delta;
  - converts the delta to BCD, adds with per-digit +6 correction, and saturates to 9999.
- Popcount, edge detect, FSM and flash counter stay in `score_tally`.

Test Plan:
- Reset, then 8'h2C on keycode -> game_state 01 after one edge; score_bcd 0000, hits_total 0.
- In PLAY, score_vec bit 3 goes 0->1 and stays high 5 frames -> new_hits 1 for one frame, score_bcd 0001, hits_total 1, flash_on high 8 frames then 0.
- In PLAY, bits 0, 5 and 9 rise on the same frame with POINTS_PER_HIT=3 -> new_hits 3, score_bcd 0009. Force score_bcd to 9995 plus one more hit -> 9998, then 9999, then holds 9999.
- Score 0098 plus 2 hits with POINTS_PER_HIT=1 -> score_bcd 0100, exercising the decimal carry across 2 digits.
- Bit 2 held high before the start key, then PLAY entered -> no hit counted. SONG_FRAMES=10 -> DONE after exactly 10 PLAY frames; rises in DONE are ignored; 8'h01 on keycode_second -> IDLE with score held.
- Reset asserted mid-PLAY with flash active and score 0042 -> next edge: IDLE, score 0000, flash_on 0, new_hits 0.
